// File: rtl/fd_stage_reg.sv
// Fetch->Decode pipeline register with a one-entry skid buffer.
// Reset, flush (req) and eret redirect clear the slot with fixed priority.
module fd_stage_reg #(
  parameter int                DATA_W     = 32,
  parameter int                EXC_W      = 5,
  parameter logic [EXC_W-1:0]  EXC_NONE   = '0,
  parameter logic [DATA_W-1:0] RESET_PC   = 32'h0000_3000,
  parameter logic [DATA_W-1:0] HANDLER_PC = 32'h0000_4180,
  parameter bit                SKID_EN    = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] instr_in,
  input  logic [EXC_W-1:0]  exc_in,
  input  logic              bd_in,
  input  logic              req,
  input  logic              eret,
  input  logic [DATA_W-1:0] epc,
  output logic              ready_out,
  output logic              valid_out,
  output logic [DATA_W-1:0] pc_out,
  output logic [DATA_W-1:0] instr_out,
  output logic [EXC_W-1:0]  exc_out,
  output logic              bd_out
);

  logic              valid_reg;
  logic [DATA_W-1:0] pc_reg;
  logic [DATA_W-1:0] instr_reg;
  logic [EXC_W-1:0]  exc_reg;
  logic              bd_reg;

  logic              skid_full;
  logic [DATA_W-1:0] skid_pc;
  logic [DATA_W-1:0] skid_instr;
  logic [EXC_W-1:0]  skid_exc;
  logic              skid_bd;

  logic redirect;
  logic flush;

  assign redirect = en & eret;
  assign flush    = req | redirect;

  generate
    if (SKID_EN) begin : g_skid
      logic              full_reg;
      logic [DATA_W-1:0] pc_sreg;
      logic [DATA_W-1:0] instr_sreg;
      logic [EXC_W-1:0]  exc_sreg;
      logic              bd_sreg;

      // Capture only while Decode is stalled; drain as soon as en returns.
      always_ff @(posedge clk) begin
        if (reset || flush) begin
          full_reg <= 1'b0;
        end else if (full_reg) begin
          if (en) full_reg <= 1'b0;
        end else if (!en && valid_in) begin
          full_reg   <= 1'b1;
          pc_sreg    <= pc_in;
          instr_sreg <= instr_in;
          exc_sreg   <= exc_in;
          bd_sreg    <= bd_in;
        end
      end

      assign skid_full  = full_reg;
      assign skid_pc    = pc_sreg;
      assign skid_instr = instr_sreg;
      assign skid_exc   = exc_sreg;
      assign skid_bd    = bd_sreg;
      assign ready_out  = ~full_reg;
    end else begin : g_noskid
      assign skid_full  = 1'b0;
      assign skid_pc    = '0;
      assign skid_instr = '0;
      assign skid_exc   = '0;
      assign skid_bd    = 1'b0;
      assign ready_out  = en;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg <= 1'b0;
      pc_reg    <= RESET_PC;
      instr_reg <= '0;
      exc_reg   <= EXC_NONE;
      bd_reg    <= 1'b0;
    end else if (req) begin
      valid_reg <= 1'b0;
      pc_reg    <= HANDLER_PC;
      instr_reg <= '0;
      exc_reg   <= EXC_NONE;
      bd_reg    <= 1'b0;
    end else if (redirect) begin
      valid_reg <= 1'b0;
      pc_reg    <= epc;
      instr_reg <= '0;
      exc_reg   <= EXC_NONE;
      bd_reg    <= 1'b0;
    end else if (en) begin
      // A held slot is older than anything upstream, so it goes first.
      if (skid_full) begin
        valid_reg <= 1'b1;
        pc_reg    <= skid_pc;
        instr_reg <= skid_instr;
        exc_reg   <= skid_exc;
        bd_reg    <= skid_bd;
      end else begin
        valid_reg <= valid_in;
        pc_reg    <= pc_in;
        instr_reg <= instr_in;
        exc_reg   <= exc_in;
        bd_reg    <= bd_in;
      end
    end
  end

  assign valid_out = valid_reg;
  assign pc_out    = pc_reg;
  assign instr_out = instr_reg;
  assign exc_out   = exc_reg;
  assign bd_out    = bd_reg;

endmodule

// File: tb/tb_fd_stage_reg.sv
// Directed plus randomized check of fd_stage_reg against a queue-based slot model.
module tb_fd_stage_reg;

  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  exc;
    logic        bd;
  } slot_t;

  logic        clk = 1'b0;
  logic        reset, en, valid_in, bd_in, req, eret;
  logic [31:0] pc_in, instr_in, epc;
  logic [4:0]  exc_in;
  logic        ready_out, valid_out, bd_out;
  logic [31:0] pc_out, instr_out;
  logic [4:0]  exc_out;

  int checks = 0;
  int errors = 0;

  slot_t model_out;
  slot_t skid_q[$];
  bit    model_init = 1'b0;

  fd_stage_reg dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .valid_in  (valid_in),
    .pc_in     (pc_in),
    .instr_in  (instr_in),
    .exc_in    (exc_in),
    .bd_in     (bd_in),
    .req       (req),
    .eret      (eret),
    .epc       (epc),
    .ready_out (ready_out),
    .valid_out (valid_out),
    .pc_out    (pc_out),
    .instr_out (instr_out),
    .exc_out   (exc_out),
    .bd_out    (bd_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Spec-level behaviour of one clock edge: the skid is a queue of at most one slot.
  task automatic model_edge(input slot_t inc, input logic rst, input logic e,
                            input logic rq, input logic er, input logic [31:0] ep);
    slot_t cleared;
    cleared = '{v: 1'b0, pc: 32'h0, instr: 32'h0, exc: 5'd0, bd: 1'b0};
    if (rst) begin
      model_out = cleared; model_out.pc = 32'h0000_3000; skid_q.delete();
    end else if (rq) begin
      model_out = cleared; model_out.pc = 32'h0000_4180; skid_q.delete();
    end else if (e && er) begin
      model_out = cleared; model_out.pc = ep; skid_q.delete();
    end else if (e) begin
      if (skid_q.size() > 0) begin
        model_out = skid_q.pop_front();
        model_out.v = 1'b1;
      end else begin
        model_out = inc;
      end
    end else if (inc.v && skid_q.size() == 0) begin
      skid_q.push_back(inc);
    end
  endtask

  task automatic step(input logic rst, input logic e, input logic v, input logic [31:0] pc,
                      input logic [31:0] ins, input logic [4:0] ex, input logic bd,
                      input logic rq, input logic er, input logic [31:0] ep);
    slot_t inc;
    @(negedge clk);
    reset = rst; en = e; valid_in = v; pc_in = pc; instr_in = ins;
    exc_in = ex; bd_in = bd; req = rq; eret = er; epc = ep;
    #1;
    if (model_init) chk("ready", ready_out, skid_q.size() == 0);
    inc = '{v: v, pc: pc, instr: ins, exc: ex, bd: bd};
    @(posedge clk);
    model_edge(inc, rst, e, rq, er, ep);
    model_init = 1'b1;
    #1;
    chk("valid", valid_out, model_out.v);
    chk("pc",    pc_out,    model_out.pc);
    chk("instr", instr_out, model_out.instr);
    chk("exc",   exc_out,   model_out.exc);
    chk("bd",    bd_out,    model_out.bd);
    $display("step rst=%0b en=%0b vin=%0b pc_in=%h req=%0b eret=%0b -> vout=%0b pc_out=%h rdy=%0b",
             rst, e, v, pc, rq, er, valid_out, pc_out, ready_out);
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; valid_in = 1'b0; pc_in = '0; instr_in = '0;
    exc_in = '0; bd_in = 1'b0; req = 1'b0; eret = 1'b0; epc = '0;

    // Reset held for two edges
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 32'h1234, 32'h5678, 5'd3, 1, 1, 1, 32'h99);
    chk("rst_pc", pc_out, 32'h3000);
    chk("rst_valid", valid_out, 1'b0);
    chk("rst_ready", ready_out, 1'b1);

    // Streaming
    step(0, 1, 1, 32'h3000, 32'hA000, 0, 0, 0, 0, 0);
    step(0, 1, 1, 32'h3004, 32'hA004, 0, 0, 0, 0, 0);
    step(0, 1, 1, 32'h3008, 32'hA008, 0, 0, 0, 0, 0);
    chk("stream_pc", pc_out, 32'h3008);
    chk("stream_valid", valid_out, 1'b1);

    // Stall with skid
    step(0, 0, 1, 32'h3010, 32'hA010, 0, 0, 0, 0, 0);
    chk("stall_hold_pc", pc_out, 32'h3008);
    chk("stall_ready", ready_out, 1'b0);
    step(0, 1, 1, 32'h3014, 32'hA014, 0, 0, 0, 0, 0);
    chk("skid_drain_pc", pc_out, 32'h3010);
    chk("skid_drain_ready", ready_out, 1'b1);
    step(0, 1, 1, 32'h3014, 32'hA014, 0, 0, 0, 0, 0);
    chk("after_drain_pc", pc_out, 32'h3014);

    // Flush while skid full
    step(0, 0, 1, 32'h3020, 32'hA020, 0, 0, 0, 0, 0);
    step(0, 0, 1, 32'h3024, 32'hA024, 0, 0, 1, 0, 0);
    chk("flush_pc", pc_out, 32'h4180);
    chk("flush_ready", ready_out, 1'b1);
    step(0, 1, 0, 32'h3028, 32'h0, 0, 0, 0, 0, 0);
    chk("flush_no_skid_pc", pc_out, 32'h3028);
    chk("flush_no_skid_valid", valid_out, 1'b0);

    // Eret with and without en, then req+eret
    step(0, 1, 1, 32'h3030, 32'hA030, 0, 0, 0, 1, 32'h3044);
    chk("eret_pc", pc_out, 32'h3044);
    chk("eret_instr", instr_out, 32'h0);
    step(0, 0, 0, 32'h3034, 32'hA034, 0, 0, 0, 1, 32'h3050);
    chk("eret_noen_pc", pc_out, 32'h3044);
    step(0, 1, 1, 32'h3038, 32'hA038, 0, 0, 1, 1, 32'h3060);
    chk("req_eret_pc", pc_out, 32'h4180);

    // Exception / delay-slot passthrough, then flush clears them
    step(0, 1, 1, 32'h3040, 32'hA040, 5'd4, 1, 0, 0, 0);
    chk("exc_pass", exc_out, 5'd4);
    chk("bd_pass", bd_out, 1'b1);
    step(0, 1, 1, 32'h3044, 32'hA044, 5'd4, 1, 1, 0, 0);
    chk("exc_flush", exc_out, 5'd0);
    chk("bd_flush", bd_out, 1'b0);

    // Randomized traffic; upstream holds its slot while ready_out is low
    begin
      logic        r_v, r_bd;
      logic [31:0] r_pc, r_ins;
      logic [4:0]  r_exc;
      r_v = 1'b1; r_pc = 32'h5000; r_ins = $urandom; r_exc = '0; r_bd = 1'b0;
      for (int i = 0; i < 400; i++) begin
        logic r_rst, r_en, r_req, r_eret;
        if (skid_q.size() == 0) begin
          r_v   = ($urandom_range(0, 3) != 0);
          r_pc  = r_pc + 4;
          r_ins = $urandom;
          r_exc = 5'($urandom_range(0, 31));
          r_bd  = 1'($urandom_range(0, 1));
        end
        r_rst  = ($urandom_range(0, 99) == 0);
        r_en   = ($urandom_range(0, 9) < 6);
        r_req  = ($urandom_range(0, 29) == 0);
        r_eret = ($urandom_range(0, 19) == 0);
        step(r_rst, r_en, r_v, r_pc, r_ins, r_exc, r_bd, r_req, r_eret, $urandom);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fd_stage_reg.md
Name: fd_stage_reg

Overview:
- Parametrised Fetch→Decode pipeline register. Successor to the fixed 32-bit F/D latch.
- Carries PC, instruction, exception code and branch-delay flag, plus an explicit valid bit.
- Adds a one-entry skid buffer, so a fetch result that arrives while Decode is stalled is held, not lost. Upstream sees backpressure through ready_out.
- Handles reset, exception/interrupt flush (req) and eret redirect with fixed priority.

Parameters:
- DATA_W, 32, width of PC, instruction, epc.
- EXC_W, 5, width of exception code.
- EXC_NONE, 0, exception code meaning "no exception" (Int).
- RESET_PC, 32'h00003000, pc_out value after reset.
- HANDLER_PC, 32'h00004180, pc_out value after req flush.
- SKID_EN, 1, 1 = skid buffer present; 0 = no skid, and ready_out is tied to en.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  Decode advance enable; 0 = stall (output registers hold).
- valid_in  in  1  fetch slot valid.
- pc_in  in  DATA_W  fetch PC.
- instr_in  in  DATA_W  fetched instruction.
- exc_in  in  EXC_W  fetch-stage exception code.
- bd_in  in  1  fetch instruction is in a delay slot.
- req  in  1  exception/interrupt flush request.
- eret  in  1  eret in Decode; redirect to epc.
- epc  in  DATA_W  return address for eret.
- ready_out  out  1  stage can accept a fetch slot this cycle.
- valid_out  out  1  Decode slot valid.
- pc_out  out  DATA_W  Decode PC.
- instr_out  out  DATA_W  Decode instruction.
- exc_out  out  EXC_W  Decode pre-exception code.
- bd_out  out  1  Decode delay-slot flag.

Behaviour:
- Reset values (reset=1 at an edge):
  - pc_out=RESET_PC, instr_out=0, exc_out=EXC_NONE, bd_out=0, valid_out=0.
  - Skid buffer emptied; ready_out=1 the following cycle.
  - Reset overrides every other input.
- Priority per edge: reset > req > (en & eret) > normal operation.
- req=1 (no reset):
  - pc_out=HANDLER_PC, instr_out=0, exc_out=EXC_NONE, bd_out=0, valid_out=0.
  - Skid emptied. The fetch slot presented this cycle is discarded.
  - req acts regardless of en.
- en=1 & eret=1 (no reset, no req):
  - pc_out=epc, instr_out=0, exc_out=EXC_NONE, bd_out=0, valid_out=0.
  - Skid emptied; the incoming slot is discarded.
  - eret with en=0 has no effect.
- ready_out = ~skid_full. This is combinational from registered state only, with no input→ready path.
- Accept: a slot is accepted when valid_in & ready_out, and no reset, req or (en&eret) is active.
- Normal operation, skid empty:
  - en=1: output registers load the incoming slot. valid_out = valid_in, with other fields copied.
  - en=0 and slot accepted: slot written to skid, skid_full=1, output registers hold.
  - en=0 and valid_in=0: nothing changes.
- Normal operation, skid full:
  - en=1: output registers load the skid contents (valid_out=1) and skid_full clears. Inputs are ignored, because upstream is held by ready_out=0.
  - en=0: everything holds.
- Latency: accepted slot to output is 1 cycle when not stalled. It is 1 cycle after en rises when the slot sat in the skid.
- No slot is ever duplicated or dropped except by flush or redirect.
- SKID_EN=0:
  - No skid storage; ready_out=en.
  - en=0 holds the outputs and valid_in is ignored.
- Simultaneous events:
  - req with eret: req wins.
  - reset with anything: reset wins.
  - Flush while skid full: both output and skid are cleared in the same edge.

Test Plan:
- Reset: hold reset 2 cycles -> pc_out=0x3000, instr_out=0, exc_out=0, bd_out=0, valid_out=0, ready_out=1.
- Streaming: en=1, valid_in=1, pc_in 0x3000,0x3004,0x3008 on successive cycles -> pc_out follows one cycle later, valid_out=1.
- Stall with skid:
  - Stimulus: en=0 one cycle while pc_in=0x3010 valid, then en=1.
  - Response: ready_out=0 during the hold; pc_out=0x3010 on the edge after en rises; ready_out=1 the cycle after.
- Flush with skid full: stall and fill skid, then req=1 -> pc_out=0x4180, valid_out=0, ready_out=1 next cycle, skid contents never appear.
- Eret:
  - en=1, eret=1, epc=0x3044 -> pc_out=0x3044, instr_out=0, valid_out=0.
  - Repeat with en=0 -> outputs unchanged.
  - req and eret together -> pc_out=0x4180.
- Exception/BD passthrough: exc_in=4 (AdEL), bd_in=1, en=1 -> exc_out=4, bd_out=1 next cycle. Then req -> exc_out=0, bd_out=0.
